// File: rtl/rom_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rom_rd_pkg                                                   |
// | Description : Shared types and default parameter values for the ROM burst |
// |               reader (state encoding, default widths and buffer depth).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rom_rd_pkg;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Burst engine state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : rom_rd_pkg
`default_nettype wire

// File: rtl/rom_rd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_rd_fifo                                                  |
// | Description : Synchronous FIFO buffering ROM words (data + last tag) on   |
// |               their way to the consumer. Head entry is read straight from |
// |               storage flops, so the output has no combinational path from |
// |               the write side. No push-to-pop bypass when empty.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, rising edge                                       |
// |   rst_n      in   asynchronous active-low reset                            |
// |   push       in   write push_data at the end of this cycle                 |
// |   push_data  in   WIDTH entry to store                                     |
// |   pop        in   consume head entry at the end of this cycle              |
// |   pop_data   out  head entry (zero after reset)                            |
// |   not_empty  out  at least one entry stored                                |
// |   count      out  number of stored entries                                 |
// +----------------------------------------------------------------------------+
module rom_rd_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // Push while full is only meaningful when the head leaves in the same cycle
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Storage is cleared so the head reads as zero immediately on reset
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule : rom_rd_fifo
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_burst_reader                                             |
// | Description : Burst read engine in front of a synchronous ROM macro with  |
// |               one-cycle read latency. Takes (address, length) requests,   |
// |               streams consecutive words to a valid/ready consumer and     |
// |               throttles ROM reads with a credit scheme so the output      |
// |               buffer never overflows under backpressure.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   CK         in   clock, rising edge                                       |
// |   RSTn       in   asynchronous active-low reset                            |
// |   req_valid  in   burst request valid                                      |
// |   req_ready  out  engine idle, request accepted on valid&ready             |
// |   req_addr   in   first word address                                       |
// |   req_len    in   beats minus one                                          |
// |   rd_valid   out  rd_data/rd_last valid                                    |
// |   rd_ready   in   consumer accepts the beat                                |
// |   rd_data    out  ROM word                                                 |
// |   rd_last    out  final beat of the burst                                  |
// |   busy       out  burst in progress                                        |
// |   rom_CS     out  ROM chip select / read strobe                            |
// |   rom_OE     out  ROM output enable (data-return cycle)                    |
// |   rom_A      out  ROM word address                                         |
// |   rom_DO     in   ROM data, valid the cycle after rom_CS                   |
// +----------------------------------------------------------------------------+
module rom_burst_reader
  import rom_rd_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              CK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              rom_CS,
  output logic              rom_OE,
  output logic [ADDR_W-1:0] rom_A,
  input  logic [WORD_W-1:0] rom_DO
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Occupancy projection needs headroom for count + return + issue
  localparam int OCC_W = CNT_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;       // next address to issue
  logic [LEN_W:0]    left_q, left_d;       // beats still to issue
  logic              cs_q, cs_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              cs_last_q, cs_last_d; // the issue in flight is the final beat
  logic              oe_q, oe_d;
  logic              oe_last_q, oe_last_d;

  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W:0]   fifo_rdata;
  logic [OCC_W-1:0]  occ_next;

  assign pop = rd_valid && rd_ready;

  // Committed buffer space as seen in the next cycle: entries left after this
  // cycle's push/pop, plus the word whose read is being issued now (it returns
  // next cycle). A new issue next cycle is allowed only if that leaves room.
  assign occ_next = OCC_W'(fifo_count) + OCC_W'(oe_q) - OCC_W'(pop) + OCC_W'(cs_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    cs_d      = 1'b0;
    a_d       = a_q;
    cs_last_d = 1'b0;
    oe_d      = cs_q;
    oe_last_d = cs_last_q;

    case (state_q)
      IDLE: begin
        // Buffer is empty here, so the first read is issued straight away;
        // left then holds beats remaining after it ((req_len+1) - 1).
        if (req_valid) begin
          state_d   = ISSUE;
          cs_d      = 1'b1;
          a_d       = req_addr;
          addr_d    = req_addr + ADDR_W'(1);
          left_d    = {1'b0, req_len};
          cs_last_d = (req_len == '0);
        end
      end
      ISSUE: begin
        if (left_q == '0) begin
          state_d = DRAIN;
        end else if (occ_next < OCC_W'(FIFO_DEPTH)) begin
          cs_d      = 1'b1;
          a_d       = addr_q;
          addr_d    = addr_q + ADDR_W'(1);
          left_d    = left_q - (LEN_W+1)'(1);
          cs_last_d = (left_q == (LEN_W+1)'(1));
        end
      end
      DRAIN: begin
        if (pop && rd_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      cs_q      <= 1'b0;
      a_q       <= '0;
      cs_last_q <= 1'b0;
      oe_q      <= 1'b0;
      oe_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      cs_q      <= cs_d;
      a_q       <= a_d;
      cs_last_q <= cs_last_d;
      oe_q      <= oe_d;
      oe_last_q <= oe_last_d;
    end
  end

  rom_rd_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CK),
    .rst_n     (RSTn),
    .push      (oe_q),
    .push_data ({oe_last_q, rom_DO}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .not_empty (rd_valid),
    .count     (fifo_count)
  );

  assign rd_data   = fifo_rdata[WORD_W-1:0];
  assign rd_last   = fifo_rdata[WORD_W];
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rom_CS    = cs_q;
  assign rom_OE    = oe_q;
  assign rom_A     = a_q;

endmodule : rom_burst_reader
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rom_burst_reader                                          |
// | Description : Directed self-checking bench for rom_burst_reader with a    |
// |               behavioural one-cycle-latency ROM (word i = i*0x01020304).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rom_burst_reader;

  logic        CK = 1'b0;
  logic        RSTn;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        rom_CS;
  logic        rom_OE;
  logic [11:0] rom_A;
  logic [31:0] rom_DO = '0;

  int compared   = 0;
  int mismatched = 0;
  int occ        = 0;
  int gaps;

  rom_burst_reader dut (
    .CK        (CK),
    .RSTn      (RSTn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .rom_CS    (rom_CS),
    .rom_OE    (rom_OE),
    .rom_A     (rom_A),
    .rom_DO    (rom_DO)
  );

  always #5 CK = ~CK;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    logic [31:0] w;
    w = {20'd0, a} * 32'h0102_0304;
    return w;
  endfunction

  // ROM macro: word appears the cycle after the CS cycle
  always @(posedge CK) begin
    if (rom_CS) rom_DO <= rom_word(rom_A);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Independent buffer-occupancy model: words returned minus beats taken.
  always @(negedge CK) begin
    if (!RSTn) begin
      occ <= 0;
    end else begin
      chk("occ_le_depth", 64'(occ <= 4), 64'd1);
      if (rom_CS) chk("cs_needs_credit", 64'((occ + int'(rom_OE)) < 4), 64'd1);
      occ <= occ + int'(rom_OE) - int'(rd_valid && rd_ready);
    end
  end

  // Consume beats of a burst starting at a0; mode 0 = always ready,
  // mode 1 = ready toggles every 3 cycles. Returns after stop_at beats.
  task automatic collect(input logic [11:0] a0, input int nbeats, input int mode,
                         input int stop_at, output int gap_cnt);
    int          got;
    int          k;
    logic        hold_v;
    logic [31:0] hold_d;
    logic        hold_l;
    logic [11:0] a;
    got = 0; k = 0; hold_v = 1'b0; hold_d = '0; hold_l = 1'b0; gap_cnt = 0;
    while (got < stop_at && k < 300) begin
      rd_ready = (mode == 0) ? 1'b1 : (((k / 3) % 2) == 0);
      if (hold_v) begin
        chk("stall_valid", 64'(rd_valid), 64'd1);
        chk("stall_data", 64'(rd_data), 64'(hold_d));
        chk("stall_last", 64'(rd_last), 64'(hold_l));
      end
      hold_v = rd_valid && !rd_ready;
      hold_d = rd_data;
      hold_l = rd_last;
      if (rd_valid && rd_ready) begin
        a = a0 + 12'(got);
        chk("beat_data", 64'(rd_data), 64'(rom_word(a)));
        chk("beat_last", 64'(rd_last), 64'(got == nbeats - 1));
        got++;
      end else if (!rd_valid) begin
        gap_cnt++;
      end
      tick();
      k++;
    end
    chk("beats_taken", 64'(got), 64'(stop_at));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
    chk({tag, "_rd_last"},   64'(rd_last),   64'd0);
    chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_rom_CS"},    64'(rom_CS),    64'd0);
    chk({tag, "_rom_OE"},    64'(rom_OE),    64'd0);
    chk({tag, "_rom_A"},     64'(rom_A),     64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b0;
    tick(); tick();
    check_reset_vals("reset");
    RSTn = 1'b1;
    tick();

    // Burst at 5, four beats, consumer always ready
    rd_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'h005; req_len = 8'd3;
    tick();
    req_valid = 1'b0;
    chk("t1_cs", 64'(rom_CS), 64'd1);
    chk("t1_a0", 64'(rom_A), 64'h005);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("t1_oe", 64'(rom_OE), 64'd1);
    chk("t1_not_yet_valid", 64'(rd_valid), 64'd0);
    chk("t1_a1", 64'(rom_A), 64'h006);
    tick();
    chk("t1_first_valid", 64'(rd_valid), 64'd1);
    chk("t1_first_data", 64'(rd_data), 64'h050A_0F14);
    collect(12'h005, 4, 0, 4, gaps);
    chk("t1_no_gaps", 64'(gaps), 64'd0);
    chk("t1_idle_ready", 64'(req_ready), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_valid", 64'(rd_valid), 64'd0);
    tick();

    // Address wrap at the top of the ROM
    req_valid = 1'b1; req_addr = 12'hFFE; req_len = 8'd3;
    tick();
    req_valid = 1'b0;
    collect(12'hFFE, 4, 0, 4, gaps);
    chk("t2_idle", 64'(req_ready), 64'd1);
    tick();

    // 16 beats with backpressure toggling every 3 cycles
    req_valid = 1'b1; req_addr = 12'h020; req_len = 8'd15;
    tick();
    req_valid = 1'b0;
    collect(12'h020, 16, 1, 16, gaps);
    rd_ready = 1'b1;
    chk("t3_idle", 64'(req_ready), 64'd1);
    chk("t3_empty", 64'(rd_valid), 64'd0);
    tick();

    // Single beat; request held high while busy must not be re-accepted
    req_valid = 1'b1; req_addr = 12'h010; req_len = 8'd0;
    tick();
    chk("t4_cs", 64'(rom_CS), 64'd1);
    chk("t4_a", 64'(rom_A), 64'h010);
    req_addr = 12'h040; req_len = 8'd5;
    tick();
    chk("t4_oe", 64'(rom_OE), 64'd1);
    chk("t4_single_issue", 64'(rom_CS), 64'd0);
    chk("t4_held_not_ready", 64'(req_ready), 64'd0);
    tick();
    chk("t4_valid", 64'(rd_valid), 64'd1);
    chk("t4_data", 64'(rd_data), 64'(rom_word(12'h010)));
    chk("t4_last", 64'(rd_last), 64'd1);
    chk("t4_no_cs", 64'(rom_CS), 64'd0);
    tick();
    chk("t4_ready_back", 64'(req_ready), 64'd1);
    chk("t4_busy_low", 64'(busy), 64'd0);
    chk("t4_empty", 64'(rd_valid), 64'd0);
    req_valid = 1'b0;
    tick();
    chk("t4_not_accepted", 64'(busy), 64'd0);
    chk("t4_no_issue", 64'(rom_CS), 64'd0);

    // Reset mid-burst after three beats
    req_valid = 1'b1; req_addr = 12'h100; req_len = 8'd7;
    tick();
    req_valid = 1'b0;
    collect(12'h100, 8, 0, 3, gaps);
    chk("t5_busy_before", 64'(busy), 64'd1);
    RSTn = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(); tick();
    RSTn = 1'b1;
    tick();
    check_reset_vals("after_rst");
    req_valid = 1'b1; req_addr = 12'h00A; req_len = 8'd1;
    tick();
    req_valid = 1'b0;
    collect(12'h00A, 2, 0, 2, gaps);
    chk("t5_idle", 64'(req_ready), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_rom_burst_reader
`default_nettype wire
